// File: rtl/fit_chi_collector.sv
// Fit-stage result collector: slot mux, chi-square cut, in-flight tracking and end-event drain.
// Optional FIT_STATS_EN: per-event saturating count of passing tracks carried in the EE word.
module fit_chi_collector #(
  parameter int CHI_W = 16,
  parameter int PAR_W = 64,
  parameter int EE_W  = 32,
  parameter int CNT_W = 5,
  localparam int OUT_W = 1 + 3 + CHI_W + PAR_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               fit_start,
  input  logic               fit_valid,
  input  logic [2:0]         fit_chi_sel,
  input  logic [6*CHI_W-1:0] chi_bus,
  input  logic [6*PAR_W-1:0] par_bus,
  input  logic [CHI_W-1:0]   chi_cut,
  input  logic               ee_valid,
  input  logic [EE_W-1:0]    ee_data,
  output logic               ee_ready,
  input  logic               fifo_out_full,
  output logic               fifo_out_we,
  output logic [OUT_W-1:0]   fifo_out_data,
  output logic [CNT_W-1:0]   inflight,
  output logic               overflow,
  output logic               seq_err
);

  typedef enum logic [1:0] {IDLE, DRAIN, EMIT} state_t;

  state_t             state_q, state_d;
  logic [CHI_W-1:0]   chi_mux;
  logic [PAR_W-1:0]   par_mux;
  logic               vld_p1;
  logic [2:0]         sel_p1;
  logic [CHI_W-1:0]   chi_p1;
  logic [PAR_W-1:0]   par_p1;
  logic [EE_W-1:0]    ee_lat;
  logic [CHI_W-1:0]   stat_val;
  logic               bad_sel, underflow, cnt_sat, pass_p1, drain_done;
  logic [OUT_W-1:0]   ee_word;

  always_comb begin
    chi_mux = '0;
    par_mux = '0;
    for (int k = 0; k < 6; k++) begin
      if (fit_chi_sel == 3'(k)) begin
        chi_mux = chi_bus[k*CHI_W +: CHI_W];
        par_mux = par_bus[k*PAR_W +: PAR_W];
      end
    end
  end

  // A result with no fit outstanding is spurious and is dropped like a bad slot.
  assign bad_sel   = fit_valid && (fit_chi_sel > 3'd5);
  assign underflow = fit_valid && !fit_start && (inflight == '0);
  assign cnt_sat   = fit_start && !fit_valid && (&inflight);

  // Stage S1: slot select
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= fit_valid && !bad_sel && !underflow;
  end

  always_ff @(posedge clock) begin
    sel_p1 <= fit_chi_sel;
    chi_p1 <= chi_mux;
    par_p1 <= par_mux;
  end

  assign pass_p1 = vld_p1 && (chi_p1 <= chi_cut);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      inflight <= '0;
      seq_err  <= 1'b0;
    end else begin
      if (fit_start && !fit_valid && !cnt_sat)      inflight <= inflight + 1'b1;
      else if (fit_valid && !fit_start && !underflow) inflight <= inflight - 1'b1;
      if (bad_sel || underflow || cnt_sat || (fit_start && state_q == DRAIN))
        seq_err <= 1'b1;
    end
  end

`ifdef FIT_STATS_EN
  function automatic logic [CHI_W-1:0] sat_inc(input logic [CHI_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [CHI_W-1:0] stat_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                stat_cnt <= '0;
    else if (state_q == EMIT)  stat_cnt <= '0;
    else if (pass_p1)          stat_cnt <= sat_inc(stat_cnt);
  end

  assign stat_val = stat_cnt;
`else
  assign stat_val = '0;
`endif

  // S1 must be empty before the marker is registered, so it can never meet a track word.
  assign drain_done = (state_q == DRAIN) && (inflight == '0) && !fit_valid && !vld_p1;
  assign ee_word    = {1'b1, 3'b000, stat_val, PAR_W'(ee_lat)};
  assign ee_ready   = (state_q == IDLE);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ee_valid) state_d = DRAIN;
      DRAIN:   if (drain_done) state_d = EMIT;
      EMIT:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (state_q == IDLE && ee_valid) ee_lat <= ee_data;
  end

  // Stage S2: cut and FIFO write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      fifo_out_we   <= 1'b0;
      fifo_out_data <= '0;
      overflow      <= 1'b0;
    end else begin
      fifo_out_we <= 1'b0;
      if (drain_done) begin
        if (fifo_out_full) overflow <= 1'b1;
        else begin
          fifo_out_we   <= 1'b1;
          fifo_out_data <= ee_word;
        end
      end else if (pass_p1) begin
        if (fifo_out_full) overflow <= 1'b1;
        else begin
          fifo_out_we   <= 1'b1;
          fifo_out_data <= {1'b0, sel_p1, chi_p1, par_p1};
        end
      end
    end
  end

endmodule

// File: tb/tb_fit_chi_collector.sv
// Scoreboard bench for fit_chi_collector: directed vectors, queue of expected FIFO words.
module tb_fit_chi_collector;

  localparam int CHI_W = 16;
  localparam int PAR_W = 64;
  localparam int EE_W  = 32;
  localparam int CNT_W = 5;
  localparam int OUT_W = 1 + 3 + CHI_W + PAR_W;

`ifdef FIT_STATS_EN
  localparam logic [CHI_W-1:0] STAT1 = 16'd1;
  localparam logic [CHI_W-1:0] STAT2 = 16'd2;
`else
  localparam logic [CHI_W-1:0] STAT1 = 16'd0;
  localparam logic [CHI_W-1:0] STAT2 = 16'd0;
`endif

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic               fit_start = 1'b0;
  logic               fit_valid = 1'b0;
  logic [2:0]         fit_chi_sel = 3'd0;
  logic [6*CHI_W-1:0] chi_bus = '0;
  logic [6*PAR_W-1:0] par_bus = '0;
  logic [CHI_W-1:0]   chi_cut = 16'd100;
  logic               ee_valid = 1'b0;
  logic [EE_W-1:0]    ee_data = '0;
  logic               ee_ready;
  logic               fifo_out_full = 1'b0;
  logic               fifo_out_we;
  logic [OUT_W-1:0]   fifo_out_data;
  logic [CNT_W-1:0]   inflight;
  logic               overflow;
  logic               seq_err;

  fit_chi_collector #(.CHI_W(CHI_W), .PAR_W(PAR_W), .EE_W(EE_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .fit_start(fit_start), .fit_valid(fit_valid),
    .fit_chi_sel(fit_chi_sel), .chi_bus(chi_bus), .par_bus(par_bus), .chi_cut(chi_cut),
    .ee_valid(ee_valid), .ee_data(ee_data), .ee_ready(ee_ready),
    .fifo_out_full(fifo_out_full), .fifo_out_we(fifo_out_we), .fifo_out_data(fifo_out_data),
    .inflight(inflight), .overflow(overflow), .seq_err(seq_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [OUT_W-1:0] w;
    int               at;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [OUT_W-1:0] w, input int at);
    exp_t e;
    e.w  = w;
    e.at = at;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  task automatic set_slot(input int k, input logic [CHI_W-1:0] c, input logic [PAR_W-1:0] p);
    chi_bus[k*CHI_W +: CHI_W] = c;
    par_bus[k*PAR_W +: PAR_W] = p;
  endtask

  // Monitor: every FIFO write must match the head of the expected queue.
  always @(negedge clock) begin
    if (fifo_out_we) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_write: got %0h at cycle %0d, expected no write", fifo_out_data, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (fifo_out_data !== e.w || (e.at >= 0 && cyc != e.at)) begin
          n_bad++;
          $display("FAIL fifo_word: got %0h at cycle %0d, expected %0h at cycle %0d",
                   fifo_out_data, cyc, e.w, e.at);
        end
      end
    end
  end

  initial begin
    logic [PAR_W-1:0] par2, para, parb;
    par2 = 64'h1122_3344_5566_7788;
    para = 64'hA0A0_0000_0000_000A;
    parb = 64'hB0B0_0000_0000_000B;

    // reset values
    do_reset();
    check("rst_ee_ready", ee_ready, 1);
    check("rst_inflight", inflight, 0);
    check("rst_we", fifo_out_we, 0);
    check("rst_overflow", overflow, 0);
    check("rst_seq_err", seq_err, 0);

    // chi cut boundary: 100 passes, 101 fails
    fit_start = 1'b1; tick(); tick(); fit_start = 1'b0;
    check("inflight_two", inflight, 2);
    set_slot(2, 16'd100, par2);
    set_slot(5, 16'd101, 64'hDEAD_BEEF_0000_0005);
    fit_valid = 1'b1; fit_chi_sel = 3'd2;
    push({1'b0, 3'd2, 16'd100, par2}, cyc + 2);
    tick();
    fit_chi_sel = 3'd5;
    tick();
    fit_valid = 1'b0;
    repeat (3) tick();
    check("inflight_drained", inflight, 0);

    // empty event: marker accepted in N, written in N+2
    ee_valid = 1'b1; ee_data = 32'h1234;
    push({1'b1, 3'd0, STAT1, 64'h1234}, cyc + 2);
    tick();
    ee_valid = 1'b0;
    check("ee_ready_drain", ee_ready, 0);
    repeat (4) tick();
    check("ee_ready_back", ee_ready, 1);

    // event with three fits in flight; marker must follow all track words
    fit_start = 1'b1; repeat (3) tick(); fit_start = 1'b0;
    ee_valid = 1'b1; ee_data = 32'hCAFE;
    tick();
    ee_valid = 1'b0;
    repeat (5) tick();
    check("ee_ready_wait", ee_ready, 0);
    check("inflight_three", inflight, 3);
    set_slot(0, 16'd10, para);
    set_slot(1, 16'd200, 64'h1);
    set_slot(3, 16'd50, parb);
    fit_valid = 1'b1; fit_chi_sel = 3'd0;
    push({1'b0, 3'd0, 16'd10, para}, cyc + 2);
    tick();
    fit_chi_sel = 3'd1;
    tick();
    fit_chi_sel = 3'd3;
    push({1'b0, 3'd3, 16'd50, parb}, cyc + 2);
    push({1'b1, 3'd0, STAT2, 64'hCAFE}, -1);
    tick();
    fit_valid = 1'b0;
    repeat (6) tick();
    check("ev_inflight", inflight, 0);
    check("ev_ee_ready", ee_ready, 1);
    check("ev_seq_err", seq_err, 0);
    check("ev_queue_drained", exp_q.size(), 0);

    // full FIFO during a passing result
    fifo_out_full = 1'b1;
    fit_start = 1'b1; tick(); fit_start = 1'b0;
    set_slot(4, 16'd5, 64'h4444);
    fit_valid = 1'b1; fit_chi_sel = 3'd4; tick(); fit_valid = 1'b0;
    repeat (3) tick();
    check("overflow_set", overflow, 1);
    fifo_out_full = 1'b0;
    repeat (3) tick();
    check("overflow_sticky", overflow, 1);
    check("overflow_inflight", inflight, 0);

    // result with nothing in flight
    check("seq_err_clean", seq_err, 0);
    set_slot(0, 16'd0, 64'h7);
    fit_valid = 1'b1; fit_chi_sel = 3'd0; tick(); fit_valid = 1'b0;
    repeat (3) tick();
    check("underflow_seq_err", seq_err, 1);
    check("underflow_inflight", inflight, 0);

    // illegal slot 7 together with a start
    do_reset();
    check("reset_clears_seq_err", seq_err, 0);
    check("reset_clears_overflow", overflow, 0);
    fit_start = 1'b1; fit_valid = 1'b1; fit_chi_sel = 3'd7;
    tick();
    fit_start = 1'b0; fit_valid = 1'b0;
    repeat (3) tick();
    check("sel7_seq_err", seq_err, 1);
    check("sel7_inflight", inflight, 0);

    // reset in the middle of a draining event
    do_reset();
    fit_start = 1'b1; repeat (4) tick(); fit_start = 1'b0;
    ee_valid = 1'b1; ee_data = 32'hBAD0; tick(); ee_valid = 1'b0;
    tick();
    check("mid_inflight", inflight, 4);
    check("mid_in_drain", ee_ready, 0);
    reset = 1'b0;
    #1;
    check("async_inflight", inflight, 0);
    check("async_ee_ready", ee_ready, 1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    check("post_ee_ready", ee_ready, 1);
    check("post_inflight", inflight, 0);
    check("post_we", fifo_out_we, 0);
    check("post_data", fifo_out_data, 0);
    check("post_overflow", overflow, 0);
    check("post_seq_err", seq_err, 0);
    repeat (8) tick();
    check("final_queue_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
